// File: rtl/rvc_asap_mem_router.sv
// Routes one master onto address-decoded slave regions; unmapped reads get an error response.
// Latency: requests pass through combinationally; unmapped-read error response one cycle after accept.
// Backpressure: reads stall while a different region has reads outstanding or OUT_DEPTH is reached.
module rvc_asap_mem_router #(
    parameter int NUM_REGIONS = 3,
    parameter int ADDR_W      = 32,
    parameter int DATA_W      = 32,
    parameter int OUT_DEPTH   = 4,
    parameter logic [NUM_REGIONS-1:0][ADDR_W-1:0] REGION_BASE  =
        {32'h0000_2000, 32'h0000_1000, 32'h0040_0000},
    parameter logic [NUM_REGIONS-1:0][ADDR_W-1:0] REGION_LIMIT =
        {32'h0000_2FFF, 32'h0000_1FFF, 32'h0040_FFFF}
) (
    input  logic                          Clock,
    input  logic                          Rst,
    input  logic                          ReqValid,
    output logic                          ReqReady,
    input  logic [ADDR_W-1:0]             ReqAddr,
    input  logic                          ReqWrEn,
    input  logic [DATA_W/8-1:0]           ReqByteEn,
    input  logic [DATA_W-1:0]             ReqWrData,
    output logic                          RspValid,
    output logic [DATA_W-1:0]             RspRdData,
    output logic                          RspErr,
    output logic [NUM_REGIONS-1:0]        SlvReqValid,
    input  logic [NUM_REGIONS-1:0]        SlvReqReady,
    output logic [ADDR_W-1:0]             SlvAddr,
    output logic                          SlvWrEn,
    output logic [DATA_W/8-1:0]           SlvByteEn,
    output logic [DATA_W-1:0]             SlvWrData,
    input  logic [NUM_REGIONS-1:0]        SlvRspValid,
    input  logic [NUM_REGIONS*DATA_W-1:0] SlvRdData,
    input  logic                          FaultClr,
    output logic                          FaultValid,
    output logic [ADDR_W-1:0]             FaultAddr,
    output logic [15:0]                   FaultCount
);

    localparam int RW = $clog2(NUM_REGIONS + 1);
    localparam int CW = $clog2(OUT_DEPTH + 1);
    localparam logic [RW-1:0] ERR_REGION = RW'(NUM_REGIONS);

    logic [RW-1:0] sel;
    logic          mapped;
    logic          permit;
    logic          tgt_rdy;
    logic          go;
    logic          rsp_vld;
    logic          is_err;
    logic          rd_acc;
    logic          flt_acc;
    logic [RW-1:0] cur_region;
    logic [CW-1:0] out_cnt;
    logic          err_pend;

    // Descending scan so the lowest-indexed overlapping region wins.
    always_comb begin
        sel    = ERR_REGION;
        mapped = 1'b0;
        for (int r = NUM_REGIONS - 1; r >= 0; r--) begin
            if (ReqAddr >= REGION_BASE[r] && ReqAddr <= REGION_LIMIT[r]) begin
                sel    = RW'(r);
                mapped = 1'b1;
            end
        end
    end

    always_comb begin
        permit = ReqWrEn ||
                 ((out_cnt < CW'(OUT_DEPTH)) && (out_cnt == '0 || cur_region == sel));
        tgt_rdy = 1'b1;
        for (int r = 0; r < NUM_REGIONS; r++) begin
            if (sel == RW'(r)) tgt_rdy = SlvReqReady[r];
        end
    end

    assign go       = Rst & ReqValid & permit;
    assign ReqReady = go & tgt_rdy;

    always_comb begin
        SlvReqValid = '0;
        for (int r = 0; r < NUM_REGIONS; r++) begin
            SlvReqValid[r] = go & (sel == RW'(r));
        end
    end

    assign SlvAddr   = ReqAddr;
    assign SlvWrEn   = ReqWrEn;
    assign SlvByteEn = ReqByteEn;
    assign SlvWrData = ReqWrData;

    // Only the region owning the outstanding reads may answer.
    always_comb begin
        is_err    = (cur_region == ERR_REGION);
        rsp_vld   = 1'b0;
        RspRdData = '0;
        if (out_cnt != '0) begin
            for (int r = 0; r < NUM_REGIONS; r++) begin
                if (cur_region == RW'(r)) begin
                    rsp_vld   = SlvRspValid[r];
                    RspRdData = SlvRdData[r*DATA_W +: DATA_W];
                end
            end
            if (is_err) rsp_vld = err_pend;
        end
    end

    assign RspValid = rsp_vld;
    assign RspErr   = rsp_vld & is_err;
    assign rd_acc   = ReqReady & ~ReqWrEn;
    assign flt_acc  = ReqReady & ~mapped;

    always_ff @(posedge Clock) begin
        if (!Rst) begin
            cur_region <= '0;
            out_cnt    <= '0;
            err_pend   <= 1'b0;
            FaultValid <= 1'b0;
            FaultAddr  <= '0;
            FaultCount <= '0;
        end else begin
            if (rd_acc) cur_region <= sel;
            case ({rd_acc, rsp_vld})
                2'b10:   out_cnt <= out_cnt + 1'b1;
                2'b01:   out_cnt <= out_cnt - 1'b1;
                default: out_cnt <= out_cnt;
            endcase
            err_pend <= rd_acc & ~mapped;
            if (FaultClr) begin
                FaultValid <= flt_acc;
                FaultAddr  <= flt_acc ? ReqAddr : '0;
                FaultCount <= flt_acc ? 16'd1 : 16'd0;
            end else if (flt_acc) begin
                FaultValid <= 1'b1;
                FaultAddr  <= ReqAddr;
                if (FaultCount != 16'hFFFF) FaultCount <= FaultCount + 16'd1;
            end
        end
    end

endmodule

// File: tb/tb_rvc_asap_mem_router.sv
// Bench for rvc_asap_mem_router: queue-based reference model plus a response scoreboard.
module tb_rvc_asap_mem_router;

    localparam int NR  = 3;
    localparam int OD  = 4;
    localparam int ERR = 3;
    localparam logic [31:0] BASE  [3] = '{32'h0040_0000, 32'h0000_1000, 32'h0000_2000};
    localparam logic [31:0] LIMIT [3] = '{32'h0040_FFFF, 32'h0000_1FFF, 32'h0000_2FFF};

    logic        Clock = 1'b0;
    logic        Rst = 1'b0;
    logic        ReqValid = 1'b0;
    logic [31:0] ReqAddr = '0;
    logic        ReqWrEn = 1'b0;
    logic [3:0]  ReqByteEn = '0;
    logic [31:0] ReqWrData = '0;
    logic [2:0]  SlvReqReady = '0;
    logic [2:0]  SlvRspValid = '0;
    logic [95:0] SlvRdData = '0;
    logic        FaultClr = 1'b0;

    logic        ReqReady, RspValid, RspErr, SlvWrEn, FaultValid;
    logic [31:0] RspRdData, SlvAddr, SlvWrData, FaultAddr;
    logic [2:0]  SlvReqValid;
    logic [3:0]  SlvByteEn;
    logic [15:0] FaultCount;

    logic        o_rdy, o_rvld, o_rerr, o_wen, o_fv;
    logic [31:0] o_rdat, o_addr, o_wdat, o_fa;
    logic [2:0]  o_svld;
    logic [3:0]  o_be;
    logic [15:0] o_fc;

    always #5 Clock = ~Clock;

    rvc_asap_mem_router dut (
        .Clock(Clock), .Rst(Rst), .ReqValid(ReqValid), .ReqReady(ReqReady),
        .ReqAddr(ReqAddr), .ReqWrEn(ReqWrEn), .ReqByteEn(ReqByteEn), .ReqWrData(ReqWrData),
        .RspValid(RspValid), .RspRdData(RspRdData), .RspErr(RspErr),
        .SlvReqValid(SlvReqValid), .SlvReqReady(SlvReqReady), .SlvAddr(SlvAddr),
        .SlvWrEn(SlvWrEn), .SlvByteEn(SlvByteEn), .SlvWrData(SlvWrData),
        .SlvRspValid(SlvRspValid), .SlvRdData(SlvRdData), .FaultClr(FaultClr),
        .FaultValid(FaultValid), .FaultAddr(FaultAddr), .FaultCount(FaultCount)
    );

    // Region 2 moved inside region 0 to exercise overlap priority.
    rvc_asap_mem_router #(
        .REGION_BASE ({32'h0040_1000, 32'h0000_1000, 32'h0040_0000}),
        .REGION_LIMIT({32'h0040_1FFF, 32'h0000_1FFF, 32'h0040_FFFF})
    ) ovl (
        .Clock(Clock), .Rst(Rst), .ReqValid(ReqValid), .ReqReady(o_rdy),
        .ReqAddr(ReqAddr), .ReqWrEn(ReqWrEn), .ReqByteEn(ReqByteEn), .ReqWrData(ReqWrData),
        .RspValid(o_rvld), .RspRdData(o_rdat), .RspErr(o_rerr),
        .SlvReqValid(o_svld), .SlvReqReady(SlvReqReady), .SlvAddr(o_addr),
        .SlvWrEn(o_wen), .SlvByteEn(o_be), .SlvWrData(o_wdat),
        .SlvRspValid(SlvRspValid), .SlvRdData(SlvRdData), .FaultClr(FaultClr),
        .FaultValid(o_fv), .FaultAddr(o_fa), .FaultCount(o_fc)
    );

    typedef struct { int region; logic [31:0] data; int due; } pend_t;
    typedef struct { logic [31:0] data; logic err; } exp_t;

    pend_t       sq[$];     // slave-side read data waiting to be returned
    exp_t        sb[$];     // expected responses in order
    int          mout[$];   // region of each outstanding read
    bit          err_due;
    logic        fv;
    logic [31:0] fa;
    logic [15:0] fc;
    int          cyc, errors, checks;
    logic [2:0]  force_rsp = '0;
    bit          noise_en;
    bit          acc;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic int decode(input logic [31:0] a);
        for (int r = 0; r < NR; r++)
            if (a >= BASE[r] && a <= LIMIT[r]) return r;
        return ERR;
    endfunction

    function automatic logic [31:0] rand_addr();
        int r = $urandom_range(2);
        case ($urandom_range(6))
            0: return BASE[r];
            1: return LIMIT[r];
            2: return BASE[r] - 1;
            3: return LIMIT[r] + 1;
            4: return BASE[r] + ($urandom % (LIMIT[r] - BASE[r] + 1));
            default: return $urandom;
        endcase
    endfunction

    // One clock cycle: drive, check at negedge, advance the model after the edge.
    task automatic step(input bit v, input logic [31:0] a, input bit w, input logic [2:0] rdy,
                        input int lat, input logic [31:0] d, input bit fclr, output bit accepted);
        int ri;
        bit permit, tgt, exp_rdy, exp_rsp, exp_err, hit;
        logic [2:0] real_v, exp_svld;
        pend_t p;
        exp_t e;
        ri = decode(a);
        real_v = '0;
        SlvRdData = {$urandom, $urandom, $urandom};
        if (sq.size() > 0 && sq[0].due <= cyc) begin
            real_v[sq[0].region] = 1'b1;
            SlvRdData[sq[0].region*32 +: 32] = sq[0].data;
        end
        SlvRspValid = real_v | force_rsp;
        for (int r = 0; r < NR; r++)
            if (noise_en && !(mout.size() > 0 && mout[0] == r) && $urandom_range(3) == 0)
                SlvRspValid[r] = 1'b1;
        ReqValid = v; ReqAddr = a; ReqWrEn = w; ReqByteEn = 4'($urandom);
        ReqWrData = $urandom; SlvReqReady = rdy; FaultClr = fclr;
        @(negedge Clock);
        permit = w || (mout.size() < OD && (mout.size() == 0 || mout[0] == ri));
        tgt = (ri == ERR) ? 1'b1 : rdy[ri];
        exp_rdy = v && permit && tgt;
        exp_svld = '0;
        if (v && permit && ri != ERR) exp_svld[ri] = 1'b1;
        exp_rsp = 1'b0; exp_err = 1'b0;
        if (mout.size() > 0) begin
            if (mout[0] == ERR) begin exp_rsp = err_due; exp_err = err_due; end
            else exp_rsp = real_v[mout[0]];
        end
        chk("req_ready", ReqReady, exp_rdy);
        chk("slv_req_valid", SlvReqValid, exp_svld);
        chk("slv_addr", SlvAddr, a);
        chk("rsp_valid", RspValid, exp_rsp);
        chk("rsp_err", RspErr, exp_err);
        chk("fault_valid", FaultValid, fv);
        chk("fault_addr", FaultAddr, fa);
        chk("fault_count", FaultCount, fc);
        @(posedge Clock); #1;
        accepted = exp_rdy;
        if (exp_rsp) void'(mout.pop_front());
        if (real_v != '0) void'(sq.pop_front());
        err_due = exp_rdy && !w && ri == ERR;
        if (exp_rdy && !w) begin
            mout.push_back(ri);
            if (ri == ERR) begin
                e.data = '0; e.err = 1'b1;
            end else begin
                p.region = ri; p.data = d;
                p.due = cyc + ((lat > 0) ? lat : int'($urandom_range(1, 5)));
                sq.push_back(p);
                e.data = d; e.err = 1'b0;
            end
            sb.push_back(e);
        end
        hit = exp_rdy && ri == ERR;
        if (fclr) begin
            fv = hit; fa = hit ? a : '0; fc = hit ? 16'd1 : 16'd0;
        end else if (hit) begin
            fv = 1'b1; fa = a;
            if (fc != 16'hFFFF) fc = fc + 16'd1;
        end
        cyc++;
    endtask

    task automatic idle(input int n);
        bit a;
        for (int i = 0; i < n; i++) step(1'b0, 32'h0, 1'b0, 3'b111, 0, 32'h0, 1'b0, a);
    endtask

    task automatic do_reset();
        Rst = 1'b0; ReqValid = 1'b1; ReqAddr = 32'h0000_1004; ReqWrEn = 1'b0;
        SlvReqReady = '1; SlvRspValid = '0; FaultClr = 1'b0;
        @(negedge Clock);
        chk("reset_req_ready", ReqReady, 1'b0);
        chk("reset_slv_req_valid", SlvReqValid, 3'b000);
        @(posedge Clock); #1;
        Rst = 1'b1; ReqValid = 1'b0;
        mout.delete(); sq.delete(); sb.delete();
        err_due = 1'b0; fv = 1'b0; fa = '0; fc = '0;
        cyc++;
    endtask

    always @(negedge Clock) begin
        exp_t e;
        if (Rst && RspValid) begin
            if (sb.size() == 0) begin
                checks++; errors++;
                $display("FAIL rsp_unexpected: got response data %h, expected no response", RspRdData);
            end else begin
                e = sb.pop_front();
                chk("rsp_data", RspRdData, e.data);
                chk("rsp_err_sb", RspErr, e.err);
            end
        end
    end

    task automatic retry_read(input string name, input logic [31:0] a);
        acc = 1'b0;
        for (int k = 0; k < 40 && !acc; k++)
            step(1'b1, a, 1'b0, 3'b111, 2, $urandom, 1'b0, acc);
        checks++;
        if (!acc) begin
            errors++;
            $display("FAIL %s: got no acceptance within 40 cycles, expected acceptance", name);
        end
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: got simulation still running, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        noise_en = 1'b0;
        do_reset();
        idle(2);

        // Overlap priority: lowest index wins.
        ReqValid = 1'b1; ReqAddr = 32'h0040_1000; ReqWrEn = 1'b1; SlvReqReady = '1;
        @(negedge Clock);
        chk("overlap_route", o_svld, 3'b001);
        chk("overlap_ready", o_rdy, 1'b1);
        ReqValid = 1'b0;
        @(posedge Clock); #1; cyc++;

        // Simple read, response two cycles later.
        step(1'b1, 32'h0000_1004, 1'b0, 3'b010, 2, 32'hDEADBEEF, 1'b0, acc);
        idle(3);
        step(1'b1, 32'h0000_2000, 1'b0, 3'b111, 1, $urandom, 1'b0, acc);
        chk("count_back_to_zero", acc, 1'b1);
        idle(2);

        // Outstanding limit.
        for (int i = 0; i < 4; i++)
            step(1'b1, 32'h0000_1000 + 32'(4 * i), 1'b0, 3'b111, 8 + i, $urandom, 1'b0, acc);
        retry_read("fifth_read", 32'h0000_1010);
        idle(20);

        // Region switch blocks reads but not writes.
        step(1'b1, 32'h0000_1000, 1'b0, 3'b111, 6, $urandom, 1'b0, acc);
        step(1'b1, 32'h0000_2000, 1'b1, 3'b111, 0, 32'h0, 1'b0, acc);
        retry_read("region_switch", 32'h0000_2000);
        idle(10);

        // Unmapped reads, including back-to-back.
        step(1'b1, 32'h0000_5000, 1'b0, 3'b000, 0, 32'h0, 1'b0, acc);
        idle(2);
        step(1'b1, 32'h0000_5000, 1'b0, 3'b000, 0, 32'h0, 1'b0, acc);
        step(1'b1, 32'h0000_6000, 1'b0, 3'b000, 0, 32'h0, 1'b0, acc);
        idle(2);

        // Fault clear alone and together with an unmapped write.
        step(1'b1, 32'h0000_7000, 1'b1, 3'b111, 0, 32'h0, 1'b1, acc);
        idle(1);
        step(1'b0, 32'h0, 1'b0, 3'b111, 0, 32'h0, 1'b1, acc);
        idle(1);

        // Reset mid-operation drops outstanding reads.
        step(1'b1, 32'h0000_9000, 1'b1, 3'b111, 0, 32'h0, 1'b0, acc);
        step(1'b1, 32'h0000_1000, 1'b0, 3'b111, 10, $urandom, 1'b0, acc);
        step(1'b1, 32'h0000_1004, 1'b0, 3'b111, 11, $urandom, 1'b0, acc);
        do_reset();
        force_rsp = 3'b010;
        idle(2);
        force_rsp = 3'b000;
        idle(1);

        noise_en = 1'b1;
        for (int i = 0; i < 3000; i++)
            step($urandom_range(3) != 0, rand_addr(), $urandom_range(3) == 0, 3'($urandom),
                 int'($urandom_range(1, 5)), $urandom, $urandom_range(31) == 0, acc);

        for (int k = 0; k < 100 && mout.size() > 0; k++) idle(1);
        idle(2);
        chk("drain_outstanding", mout.size(), 0);
        chk("drain_scoreboard", sb.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
